dmem_arbiter: RTL and testbench

- Shares the single registered data RAM between the pipelined core's load/store port (requester 0) and an auxiliary master (requester 1), e.g. a program loader or debug port.
- Issues at most one access per cycle, stalls the core when it loses arbitration, and routes the 1-cycle-late RAM read data back to the correct requester.
- Sits between the core's daddr/ddata_w/mem_read/mem_write and the RAM's address/we/re/data pins.

---
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arbiter.sv | 107 ++++++++++
 tb/tb_dmem_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU load/store port, auxiliary master port,
// registered data RAM pins and the LED register output.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned DATA_SIZE = 32
);
  logic                 cpu_read;
  logic                 cpu_write;
  logic [ADDR_SIZE-1:0] cpu_addr;
  logic [DATA_SIZE-1:0] cpu_wdata;
  logic [DATA_SIZE-1:0] cpu_rdata;
  logic                 cpu_rvalid;
  logic                 cpu_stall;

  logic                 aux_req;
  logic                 aux_we;
  logic [ADDR_SIZE-1:0] aux_addr;
  logic [DATA_SIZE-1:0] aux_wdata;
  logic                 aux_ack;
  logic [DATA_SIZE-1:0] aux_rdata;
  logic                 aux_rvalid;

  logic [ADDR_SIZE-1:0] ram_addr;
  logic                 ram_we;
  logic                 ram_re;
  logic [DATA_SIZE-1:0] ram_wdata;
  logic [DATA_SIZE-1:0] ram_rdata;

  logic [7:0]           LED;

  // Arbiter side
  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_rvalid, cpu_stall,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_ack, aux_rdata, aux_rvalid,
    output ram_addr, ram_we, ram_re, ram_wdata,
    input  ram_rdata,
    output LED
  );

  // Requesters and RAM side
  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_rvalid, cpu_stall,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_ack, aux_rdata, aux_rvalid,
    input  ram_addr, ram_we, ram_re, ram_wdata,
    output ram_rdata,
    input  LED
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single registered data RAM (CPU vs aux, starvation-limited).
// Optional LED MMIO register enabled by defining DMEM_LED_MMIO_EN.
module dmem_arbiter #(
  parameter int unsigned          ADDR_SIZE    = 10,
  parameter int unsigned          DATA_SIZE    = 32,
  parameter int unsigned          STARVE_LIMIT = 4,
  parameter logic [ADDR_SIZE-1:0] LED_ADDR     = ADDR_SIZE'(10'h3FF)
) (
  input logic           CLK,
  input logic           RESET,
  dmem_arbiter_if.slave bus
);

`ifdef DMEM_LED_MMIO_EN
  localparam logic LED_EN = 1'b1;
`else
  localparam logic LED_EN = 1'b0;
`endif

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_AUX} owner_t;

  owner_t               rd_owner;
  logic                 rd_led;
  logic [3:0]           starve_cnt;
  logic [7:0]           led_q;
  logic [DATA_SIZE-1:0] cpu_rdata_q;
  logic [DATA_SIZE-1:0] aux_rdata_q;

  logic                 cpu_req;
  logic                 aux_gnt;
  logic                 cpu_gnt;
  logic                 sel_we;
  logic                 sel_re;
  logic                 led_hit;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [DATA_SIZE-1:0] sel_wdata;
  logic [DATA_SIZE-1:0] ret_data;

  always_comb begin
    cpu_req = bus.cpu_read | bus.cpu_write;
    aux_gnt = bus.aux_req & (~cpu_req | (starve_cnt == STARVE_MAX));
    cpu_gnt = cpu_req & ~aux_gnt;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    // read+write together from the CPU is a write only
    sel_we    = cpu_gnt & bus.cpu_write;
    sel_re    = cpu_gnt & bus.cpu_read & ~bus.cpu_write;
    if (aux_gnt) begin
      sel_addr  = bus.aux_addr;
      sel_wdata = bus.aux_wdata;
      sel_we    = bus.aux_we;
      sel_re    = ~bus.aux_we;
    end
    led_hit = LED_EN && (sel_addr == LED_ADDR);
  end

  assign ret_data = rd_led ? DATA_SIZE'(led_q) : bus.ram_rdata;

  assign bus.ram_addr   = sel_addr;
  assign bus.ram_wdata  = sel_wdata;
  assign bus.ram_we     = sel_we & ~led_hit;
  assign bus.ram_re     = sel_re & ~led_hit;
  assign bus.cpu_stall  = cpu_req & ~cpu_gnt;
  assign bus.aux_ack    = aux_gnt;
  assign bus.LED        = led_q;

  // Return data is presented during the rvalid cycle, then held in the capture register.
  assign bus.cpu_rvalid = (rd_owner == OWN_CPU);
  assign bus.aux_rvalid = (rd_owner == OWN_AUX);
  assign bus.cpu_rdata  = bus.cpu_rvalid ? ret_data : cpu_rdata_q;
  assign bus.aux_rdata  = bus.aux_rvalid ? ret_data : aux_rdata_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_owner    <= OWN_NONE;
      rd_led      <= 1'b0;
      starve_cnt  <= '0;
      led_q       <= '0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
    end else begin
      if (aux_gnt)
        starve_cnt <= '0;
      else if (bus.aux_req && (starve_cnt != STARVE_MAX))
        starve_cnt <= starve_cnt + 4'd1;

      if (sel_we && led_hit)
        led_q <= sel_wdata[7:0];

      if (!sel_re)
        rd_owner <= OWN_NONE;
      else if (aux_gnt)
        rd_owner <= OWN_AUX;
      else
        rd_owner <= OWN_CPU;
      rd_led <= sel_re & led_hit;

      if (rd_owner == OWN_CPU)
        cpu_rdata_q <= ret_data;
      if (rd_owner == OWN_AUX)
        aux_rdata_q <= ret_data;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded bench for dmem_arbiter: directed vectors, RAM model, read-return monitor.
module tb_dmem_arbiter;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  dmem_arbiter_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

  dmem_arbiter #(
    .ADDR_SIZE(AW),
    .DATA_SIZE(DW),
    .STARVE_LIMIT(4),
    .LED_ADDR(10'h3FF)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  logic [DW-1:0] mem [0:1023];
  always @(posedge CLK) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
  end

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] cpu_q [$];
  logic [DW-1:0] aux_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read-return monitor
  always @(negedge CLK) begin
    if (!RESET) begin
      if (bus.cpu_rvalid === 1'b1) begin
        if (cpu_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_rvalid_unexpected: got rvalid with data %h expected no return", bus.cpu_rdata);
        end else check("cpu_rdata_return", bus.cpu_rdata, cpu_q.pop_front());
      end
      if (bus.aux_rvalid === 1'b1) begin
        if (aux_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL aux_rvalid_unexpected: got rvalid with data %h expected no return", bus.aux_rdata);
        end else check("aux_rdata_return", bus.aux_rdata, aux_q.pop_front());
      end
    end
  end

  task automatic cyc_begin();
    @(posedge CLK);
    #1;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    bus.aux_req   = 1'b0;
    bus.aux_we    = 1'b0;
  endtask

  logic [AW-1:0] pre_addr [5] = '{10'h020, 10'h005, 10'h006, 10'h001, 10'h002};
  logic [DW-1:0] pre_data [5] = '{32'h12345678, 32'h05050505, 32'h06060606, 32'h11111111, 32'h22222222};

  initial begin
    RESET = 1'b1;
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.aux_req = 1'b0; bus.aux_we = 1'b0; bus.aux_addr = '0; bus.aux_wdata = '0;

    repeat (2) @(negedge CLK);
    check("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    check("rst_aux_rvalid", bus.aux_rvalid, 1'b0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    check("rst_aux_rdata", bus.aux_rdata, 32'h0);
    check("rst_led", bus.LED, 8'h00);
    @(posedge CLK); #1 RESET = 1'b0;

    // Preload through the aux port
    for (int i = 0; i < 5; i++) begin
      cyc_begin();
      bus.aux_req = 1'b1; bus.aux_we = 1'b1;
      bus.aux_addr = pre_addr[i]; bus.aux_wdata = pre_data[i];
      @(negedge CLK);
      check("pre_aux_ack", bus.aux_ack, 1'b1);
      check("pre_ram_we", bus.ram_we, 1'b1);
    end

    // CPU write then read back
    cyc_begin();
    bus.cpu_write = 1'b1; bus.cpu_addr = 10'h010; bus.cpu_wdata = 32'hDEADBEEF;
    @(negedge CLK);
    check("t1_ram_we", bus.ram_we, 1'b1);
    check("t1_ram_re", bus.ram_re, 1'b0);
    check("t1_ram_addr", 32'(bus.ram_addr), 32'h010);
    check("t1_ram_wdata", bus.ram_wdata, 32'hDEADBEEF);
    check("t1_stall_w", bus.cpu_stall, 1'b0);
    cyc_begin();
    bus.cpu_read = 1'b1; bus.cpu_addr = 10'h010;
    @(negedge CLK);
    check("t1_ram_re_r", bus.ram_re, 1'b1);
    check("t1_stall_r", bus.cpu_stall, 1'b0);
    cpu_q.push_back(32'hDEADBEEF);
    cyc_begin();
    @(negedge CLK);
    check("t1_rvalid", bus.cpu_rvalid, 1'b1);
    cyc_begin();
    @(negedge CLK);
    check("t1_rvalid_pulse", bus.cpu_rvalid, 1'b0);
    check("t1_rdata_hold", bus.cpu_rdata, 32'hDEADBEEF);

    // Aux alone read
    cyc_begin();
    bus.aux_req = 1'b1; bus.aux_addr = 10'h020;
    @(negedge CLK);
    check("t2_aux_ack", bus.aux_ack, 1'b1);
    check("t2_ram_re", bus.ram_re, 1'b1);
    check("t2_ram_addr", 32'(bus.ram_addr), 32'h020);
    aux_q.push_back(32'h12345678);
    cyc_begin();
    @(negedge CLK);
    check("t2_aux_rvalid", bus.aux_rvalid, 1'b1);
    check("t2_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    cyc_begin();
    @(negedge CLK);
    check("t2_aux_rvalid_pulse", bus.aux_rvalid, 1'b0);
    check("t2_aux_rdata_hold", bus.aux_rdata, 32'h12345678);

    // Contention: aux wins every fifth cycle
    for (int i = 0; i < 10; i++) begin
      cyc_begin();
      bus.cpu_read = 1'b1; bus.cpu_addr = 10'h005;
      bus.aux_req = 1'b1; bus.aux_addr = 10'h006;
      @(negedge CLK);
      check("t3_aux_ack", bus.aux_ack, 32'((i % 5) == 4));
      check("t3_cpu_stall", bus.cpu_stall, 32'((i % 5) == 4));
      if ((i % 5) == 4) aux_q.push_back(32'h06060606);
      else cpu_q.push_back(32'h05050505);
    end

    // Interleaved reads by alternating owners
    cyc_begin();
    bus.cpu_read = 1'b1; bus.cpu_addr = 10'h001;
    @(negedge CLK);
    check("t4_cpu_stall", bus.cpu_stall, 1'b0);
    cpu_q.push_back(32'h11111111);
    cyc_begin();
    bus.aux_req = 1'b1; bus.aux_addr = 10'h002;
    @(negedge CLK);
    check("t4_aux_ack", bus.aux_ack, 1'b1);
    check("t4_c1_cpu_rvalid", bus.cpu_rvalid, 1'b1);
    check("t4_c1_aux_rvalid", bus.aux_rvalid, 1'b0);
    aux_q.push_back(32'h22222222);
    cyc_begin();
    @(negedge CLK);
    check("t4_c2_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    check("t4_c2_aux_rvalid", bus.aux_rvalid, 1'b1);
    cyc_begin();
    @(negedge CLK);
    check("t4_cpu_rdata", bus.cpu_rdata, 32'h11111111);
    check("t4_aux_rdata", bus.aux_rdata, 32'h22222222);

    // Read and write together: a write, no return
    cyc_begin();
    bus.cpu_read = 1'b1; bus.cpu_write = 1'b1; bus.cpu_addr = 10'h030; bus.cpu_wdata = 32'hCAFEF00D;
    @(negedge CLK);
    check("t5_ram_we", bus.ram_we, 1'b1);
    check("t5_ram_re", bus.ram_re, 1'b0);
    cyc_begin();
    @(negedge CLK);
    check("t5_no_rvalid", bus.cpu_rvalid, 1'b0);
    cyc_begin();
    bus.cpu_read = 1'b1; bus.cpu_addr = 10'h030;
    @(negedge CLK);
    cpu_q.push_back(32'hCAFEF00D);
    cyc_begin();
    @(negedge CLK);

    // Reset while a CPU read is pending, with the starve counter nonzero
    for (int i = 0; i < 2; i++) begin
      cyc_begin();
      bus.cpu_write = 1'b1; bus.cpu_addr = 10'h040; bus.cpu_wdata = 32'h1;
      bus.aux_req = 1'b1; bus.aux_addr = 10'h020;
      @(negedge CLK);
      check("t6_pre_aux_ack", bus.aux_ack, 1'b0);
    end
    cyc_begin();
    bus.cpu_read = 1'b1; bus.cpu_addr = 10'h010;
    @(negedge CLK);
    check("t6_ram_re", bus.ram_re, 1'b1);
    cyc_begin();
    RESET = 1'b1;
    @(negedge CLK);
    check("t6_rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    check("t6_rst_aux_rvalid", bus.aux_rvalid, 1'b0);
    check("t6_rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    check("t6_rst_aux_rdata", bus.aux_rdata, 32'h0);
    check("t6_rst_led", bus.LED, 8'h00);
    cyc_begin();
    RESET = 1'b0;
    @(negedge CLK);
    check("t6_post_rvalid", bus.cpu_rvalid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc_begin();
      bus.cpu_write = 1'b1; bus.cpu_addr = 10'h040; bus.cpu_wdata = 32'(i);
      bus.aux_req = 1'b1; bus.aux_addr = 10'h020;
      @(negedge CLK);
      check("t6_starve_aux_ack", bus.aux_ack, 32'(i == 4));
      check("t6_starve_cpu_stall", bus.cpu_stall, 32'(i == 4));
      if (i == 4) aux_q.push_back(32'h12345678);
    end

    // LED address
    cyc_begin();
    bus.cpu_write = 1'b1; bus.cpu_addr = 10'h3FF; bus.cpu_wdata = 32'h123456A5;
    @(negedge CLK);
`ifdef DMEM_LED_MMIO_EN
    check("t7_led_ram_we", bus.ram_we, 1'b0);
`else
    check("t7_led_ram_we", bus.ram_we, 1'b1);
`endif
    cyc_begin();
    @(negedge CLK);
`ifdef DMEM_LED_MMIO_EN
    check("t7_led", bus.LED, 8'hA5);
`else
    check("t7_led", bus.LED, 8'h00);
`endif
    cyc_begin();
    bus.cpu_read = 1'b1; bus.cpu_addr = 10'h3FF;
    @(negedge CLK);
`ifdef DMEM_LED_MMIO_EN
    check("t7_led_ram_re", bus.ram_re, 1'b0);
    cpu_q.push_back(32'h000000A5);
`else
    check("t7_led_ram_re", bus.ram_re, 1'b1);
    cpu_q.push_back(32'h123456A5);
`endif
    repeat (3) begin
      cyc_begin();
      @(negedge CLK);
    end
    check("end_cpu_q_empty", 32'(cpu_q.size()), 32'h0);
    check("end_aux_q_empty", 32'(aux_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
